// File: rtl/hazard2_soc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard2_soc_pkg
// Purpose  : Shared constants for the hazard2 SoC: sequencer opcodes, GPIO
//            register offsets, sequencer state encoding and an instruction
//            word builder used by the program ROM.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard2_soc_pkg;

   // Opcodes, instruction bits [31:28]; every value from OP_HALT upward halts
   localparam logic [3:0] OP_LDI   = 4'd0;
   localparam logic [3:0] OP_ADDI  = 4'd1;
   localparam logic [3:0] OP_STORE = 4'd2;
   localparam logic [3:0] OP_LOAD  = 4'd3;
   localparam logic [3:0] OP_WAIT  = 4'd4;
   localparam logic [3:0] OP_JMP   = 4'd5;
   localparam logic [3:0] OP_HALT  = 4'd6;

   // GPIO register byte offsets
   localparam logic [3:0] REG_DATA_OUT = 4'h0;
   localparam logic [3:0] REG_DIR      = 4'h4;
   localparam logic [3:0] REG_DATA_IN  = 4'h8;

   typedef enum logic [1:0] {
      ST_EXEC = 2'd0,
      ST_DATA = 2'd1,
      ST_WAIT = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   function automatic logic [31:0] mk_instr(input logic [3:0] op, input logic [27:0] operand);
      return {op, operand};
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard2_gpio.sv
`default_nettype none
// ============================================================================
// Module   : hazard2_gpio
// Purpose  : GPIO register block on a two-phase (address, then data) bus.
//            DATA_OUT (0x0, rw), DIR (0x4, rw), DATA_IN (0x8, ro, 2-flop
//            synchronised pad input). Unmapped reads return 0, writes to
//            read-only or unmapped offsets are dropped.
// Ports    : i_clk, i_rst        - clock, async active-high reset
//            i_addr_valid        - address phase this cycle
//            i_write, i_addr     - address-phase direction and byte offset
//            i_wdata             - write data, valid during the data phase
//            o_rdata             - read data, valid during the data phase
//            i_gpio_in           - pad input
//            o_gpio_out, o_gpio_oe - output data and direction registers
// Revision : 1.0 - initial release
// ============================================================================
module hazard2_gpio
   import hazard2_soc_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_addr_valid,
   input  logic        i_write,
   input  logic [3:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   input  logic [31:0] i_gpio_in,
   output logic [31:0] o_gpio_out,
   output logic [31:0] o_gpio_oe
);

   logic        r_dphase;
   logic        r_write;
   logic [3:0]  r_addr;
   logic [31:0] r_data_out;
   logic [31:0] r_dir;
   logic [31:0] r_sync_q1;
   logic [31:0] r_sync_q2;

   // Address phase is captured here; the data phase follows one cycle later.
   // Reset clears r_dphase, so an in-flight transaction never commits.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dphase   <= 1'b0;
         r_write    <= 1'b0;
         r_addr     <= 4'h0;
         r_data_out <= 32'h0;
         r_dir      <= 32'h0;
         r_sync_q1  <= 32'h0;
         r_sync_q2  <= 32'h0;
      end else begin
         r_dphase  <= i_addr_valid;
         if (i_addr_valid) begin
            r_write <= i_write;
            r_addr  <= i_addr;
         end
         r_sync_q1 <= i_gpio_in;
         r_sync_q2 <= r_sync_q1;
         if (r_dphase && r_write) begin
            case (r_addr)
               REG_DATA_OUT: r_data_out <= i_wdata;
               REG_DIR:      r_dir      <= i_wdata;
               default:      ;
            endcase
         end
      end
   end

   always_comb begin
      o_rdata = 32'h0;
      case (r_addr)
         REG_DATA_OUT: o_rdata = r_data_out;
         REG_DIR:      o_rdata = r_dir;
         REG_DATA_IN:  o_rdata = r_sync_q2;
         default:      o_rdata = 32'h0;
      endcase
   end

   assign o_gpio_out = r_data_out;
   assign o_gpio_oe  = r_dir;

endmodule
`default_nettype wire

// File: rtl/hazard2_soc.sv
`default_nettype none
// ============================================================================
// Module   : hazard2_soc
// Purpose  : Tiny accumulator sequencer with a 16-word program ROM driving a
//            GPIO block. The built-in program sets the direction register and
//            then counts up on GPIO_OUT forever.
// Ports    : HCLK     - clock, rising edge
//            HRESET   - async active-high reset
//            GPIO_OUT - output data register
//            GPIO_OE  - output-enable (direction) register
//            GPIO_IN  - pad input (visible only through DATA_IN reads)
// Revision : 1.0 - initial release
// ============================================================================
module hazard2_soc
   import hazard2_soc_pkg::*;
#(
   parameter logic [31:0] OE_INIT   = 32'h0000_00FF,
   parameter int unsigned LOOP_WAIT = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   output logic [31:0] GPIO_OUT,
   output logic [31:0] GPIO_OE,
   input  logic [31:0] GPIO_IN
);

   state_t      r_state;
   logic [31:0] r_a;
   logic [3:0]  r_pc;
   logic [15:0] r_wait_cnt;

   state_t      w_state_nxt;
   logic [31:0] w_a_nxt;
   logic [3:0]  w_pc_nxt;
   logic [15:0] w_cnt_nxt;
   logic [31:0] w_instr;
   logic [3:0]  w_op;
   logic [27:0] w_operand;
   logic        w_bus_valid;
   logic        w_bus_write;
   logic [31:0] w_rdata;

   // Program ROM; the LDI operand field is 28 bits wide, so OE_INIT[31:28]
   // cannot be expressed by the program.
   always_comb begin
      w_instr = mk_instr(OP_HALT, 28'h0);
      case (r_pc)
         4'd0: w_instr = mk_instr(OP_LDI,   OE_INIT[27:0]);
         4'd1: w_instr = mk_instr(OP_STORE, 28'(REG_DIR));
         4'd2: w_instr = mk_instr(OP_LDI,   28'h0);
         4'd3: w_instr = mk_instr(OP_STORE, 28'(REG_DATA_OUT));
         4'd4: w_instr = mk_instr(OP_ADDI,  28'h1);
         4'd5: w_instr = mk_instr(OP_WAIT,  28'(LOOP_WAIT));
         4'd6: w_instr = mk_instr(OP_JMP,   28'h3);
         default: w_instr = mk_instr(OP_HALT, 28'h0);
      endcase
   end

   assign w_op      = w_instr[31:28];
   assign w_operand = w_instr[27:0];

   // PC stays put during DATA, so w_op still names the STORE/LOAD in flight
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_wait_cnt;
      w_bus_valid = 1'b0;
      w_bus_write = 1'b0;
      case (r_state)
         ST_EXEC: begin
            case (w_op)
               OP_LDI: begin
                  w_a_nxt  = {4'h0, w_operand};
                  w_pc_nxt = r_pc + 4'd1;
               end
               OP_ADDI: begin
                  w_a_nxt  = r_a + {4'h0, w_operand};
                  w_pc_nxt = r_pc + 4'd1;
               end
               OP_STORE, OP_LOAD: begin
                  w_bus_valid = 1'b1;
                  w_bus_write = (w_op == OP_STORE);
                  w_state_nxt = ST_DATA;
               end
               OP_WAIT: begin
                  if (w_operand[15:0] != 16'h0) begin
                     w_cnt_nxt   = w_operand[15:0];
                     w_state_nxt = ST_WAIT;
                  end else begin
                     w_pc_nxt = r_pc + 4'd1;
                  end
               end
               OP_JMP: w_pc_nxt = w_operand[3:0];
               default: w_state_nxt = ST_HALT;
            endcase
         end
         ST_DATA: begin
            if (w_op == OP_LOAD) begin
               w_a_nxt = w_rdata;
            end
            w_pc_nxt    = r_pc + 4'd1;
            w_state_nxt = ST_EXEC;
         end
         ST_WAIT: begin
            w_cnt_nxt = r_wait_cnt - 16'd1;
            if (r_wait_cnt <= 16'd1) begin
               w_pc_nxt    = r_pc + 4'd1;
               w_state_nxt = ST_EXEC;
            end
         end
         default: w_state_nxt = ST_HALT;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state    <= ST_EXEC;
         r_a        <= 32'h0;
         r_pc       <= 4'h0;
         r_wait_cnt <= 16'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_a        <= w_a_nxt;
         r_pc       <= w_pc_nxt;
         r_wait_cnt <= w_cnt_nxt;
      end
   end

   hazard2_gpio u_gpio (
      .i_clk        (HCLK),
      .i_rst        (HRESET),
      .i_addr_valid (w_bus_valid),
      .i_write      (w_bus_write),
      .i_addr       (w_operand[3:0]),
      .i_wdata      (r_a),
      .o_rdata      (w_rdata),
      .i_gpio_in    (GPIO_IN),
      .o_gpio_out   (GPIO_OUT),
      .o_gpio_oe    (GPIO_OE)
   );

endmodule
`default_nettype wire

// File: tb/tb_hazard2_soc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard2_soc
// Purpose  : Self-checking bench for hazard2_soc. Three instances share clock
//            and reset: default parameters with a tristate loopback on
//            GPIO_IN, LOOP_WAIT=0 and LOOP_WAIT=10 with a fixed pad pattern.
//            Expected outputs come from a closed-form model of the boot
//            program timing: DIR written at edge 3, DATA_OUT = v at edge
//            6 + v*(5+LOOP_WAIT).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard2_soc;
   import hazard2_soc_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] w_out_a, w_oe_a, w_out_b, w_oe_b, w_out_c, w_oe_c;
   logic [31:0] r_pad_fixed;
   wire  [31:0] w_port = (w_oe_a != 32'h0) ? w_out_a : 32'hzzzz_zzzz;

   int checks = 0;
   int errors = 0;
   logic r_seen_halt;

   always #5 HCLK = ~HCLK;

   hazard2_soc dut_a (
      .HCLK(HCLK), .HRESET(HRESET), .GPIO_OUT(w_out_a), .GPIO_OE(w_oe_a), .GPIO_IN(w_port)
   );
   hazard2_soc #(.LOOP_WAIT(0)) dut_b (
      .HCLK(HCLK), .HRESET(HRESET), .GPIO_OUT(w_out_b), .GPIO_OE(w_oe_b), .GPIO_IN(r_pad_fixed)
   );
   hazard2_soc #(.LOOP_WAIT(10)) dut_c (
      .HCLK(HCLK), .HRESET(HRESET), .GPIO_OUT(w_out_c), .GPIO_OE(w_oe_c), .GPIO_IN(r_pad_fixed)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_out(input int k, input int period);
      if (k < 6) return 32'h0;
      return 32'((k - 6) / period);
   endfunction

   function automatic logic [31:0] exp_oe(input int k);
      return (k >= 3) ? 32'h0000_00FF : 32'h0;
   endfunction

   // Called at the falling edge after rising edge k (k counted from release)
   task automatic check_edge(input int k);
      check($sformatf("a_out k=%0d", k), w_out_a, exp_out(k, 9));
      check($sformatf("a_oe k=%0d", k),  w_oe_a,  exp_oe(k));
      check($sformatf("a_x k=%0d", k),   {31'h0, $isunknown({w_out_a, w_oe_a})}, 32'h0);
      check($sformatf("b_out k=%0d", k), w_out_b, exp_out(k, 5));
      check($sformatf("b_oe k=%0d", k),  w_oe_b,  exp_oe(k));
      check($sformatf("c_out k=%0d", k), w_out_c, exp_out(k, 15));
      check($sformatf("c_oe k=%0d", k),  w_oe_c,  exp_oe(k));
      if (k >= 5)
         check($sformatf("a_din k=%0d", k), dut_a.u_gpio.r_sync_q2, exp_out(k - 2, 9));
      if (k >= 2)
         check($sformatf("b_din k=%0d", k), dut_b.u_gpio.r_sync_q2, r_pad_fixed);
   endtask

   task automatic tick();
      @(posedge HCLK);
      @(negedge HCLK);
      if (dut_a.r_state == ST_HALT || dut_b.r_state == ST_HALT || dut_c.r_state == ST_HALT)
         r_seen_halt = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a_out"}, w_out_a, 32'h0);
      check({tag, "_a_oe"},  w_oe_a,  32'h0);
      check({tag, "_b_out"}, w_out_b, 32'h0);
      check({tag, "_c_oe"},  w_oe_c,  32'h0);
      check({tag, "_b_din"}, dut_b.u_gpio.r_sync_q2, 32'h0);
   endtask

   initial begin
      int k;
      r_pad_fixed = 32'hDEAD_BEEF;
      r_seen_halt = 1'b0;
      HRESET      = 1'b0;
      #2 HRESET   = 1'b1;
      #1 check_all_zero("rst_async");
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check_all_zero("rst_hold");
      HRESET = 1'b0;

      // Reset release and first counter steps
      for (k = 1; k <= 50; k++) begin
         tick();
         check_edge(k);
      end

      // Advance until the default instance shows 5, then reset mid-run
      while (w_out_a != 32'd5 && k <= 80) begin
         tick();
         check_edge(k);
         k++;
      end
      check("reach_5", w_out_a, 32'd5);
      @(posedge HCLK);
      #1 HRESET = 1'b1;
      #1 check_all_zero("rst_mid");
      @(posedge HCLK);
      @(posedge HCLK);
      @(negedge HCLK);
      check_all_zero("rst_mid_hold");
      HRESET = 1'b0;

      // Timing must repeat from edge 1; then the long run
      r_seen_halt = 1'b0;
      for (k = 1; k <= 10000; k++) begin
         tick();
         if (k <= 60) check_edge(k);
      end
      check("long_a_out", w_out_a, exp_out(10000, 9));
      check("long_a_min", {31'h0, (w_out_a >= 32'd1100)}, 32'h1);
      check("long_b_out", w_out_b, exp_out(10000, 5));
      check("long_c_out", w_out_c, exp_out(10000, 15));
      check("no_halt", {31'h0, r_seen_halt}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard2_soc.md
HAZARD2_SOC -- requirements
Module: hazard2_soc

Interface
REQ-001 SHALL have parameter OE_INIT, default 32'h0000_00FF, the value the boot program writes to the GPIO direction register.
REQ-002 SHALL have parameter LOOP_WAIT, default 4, the WAIT operand in the boot program loop.
REQ-003 SHALL have port HCLK, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port HRESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port GPIO_OUT, output, 32 bits: the GPIO output data register.
REQ-006 SHALL have port GPIO_OE, output, 32 bits: the GPIO output-enable (direction) register.
REQ-007 SHALL have port GPIO_IN, input, 32 bits: the GPIO pad input.

Function
REQ-008 SHALL contain a sequencer with a 32-bit accumulator A, a 4-bit PC and a 16-entry combinational program ROM; instruction word is [31:28] opcode, [27:0] operand.
REQ-009 SHALL implement these opcodes:
- 0 LDI: A = zero-extended operand.
- 1 ADDI: A = A + zero-extended operand, modulo 2^32 (wraps, no flag).
- 2 STORE: write A to byte offset operand[3:0].
- 3 LOAD: A = read data from operand[3:0].
- 4 WAIT: stall operand[15:0] cycles.
- 5 JMP: PC = operand[3:0].
- 6-15 HALT.
REQ-010 SHALL use sequencer states EXEC, DATA, WAIT and HALT.
- LDI, ADDI and JMP SHALL complete in 1 cycle in EXEC.
- STORE and LOAD SHALL issue the address phase in EXEC and complete the data phase in DATA, for 2 cycles total, then PC+1.
- WAIT n with n>0 SHALL load a counter with n and enter WAIT, decrementing each cycle and leaving with PC+1 when the counter reaches 1 (1+n cycles total).
- WAIT 0 SHALL behave as a 1-cycle NOP.
- HALT SHALL stay in HALT until reset.
- PC SHALL wrap from 15 to 0.
REQ-011 SHALL connect the sequencer to the GPIO block over an internal two-phase (address then data) bus; a register write takes effect at the clock edge that ends the data phase.
REQ-012 SHALL implement GPIO register map:
- 0x0 DATA_OUT (read/write) drives GPIO_OUT.
- 0x4 DIR (read/write) drives GPIO_OE.
- 0x8 DATA_IN (read-only) returns GPIO_IN after a 2-flop synchronizer.
- Writes to 0x8 and to unmapped offsets SHALL be ignored; reads of unmapped offsets SHALL return 0.
REQ-013 SHALL hold this ROM content:
- 0 LDI OE_INIT
- 1 STORE 0x4
- 2 LDI 0
- 3 STORE 0x0
- 4 ADDI 1
- 5 WAIT LOOP_WAIT
- 6 JMP 3
- 7-15 HALT
REQ-014 SHALL make GPIO_OUT count 0,1,2,... with one increment every 5+LOOP_WAIT cycles (9 by default), wrapping 0xFFFFFFFF to 0.
REQ-015 SHALL let GPIO_IN influence only the DATA_IN read value, never GPIO_OUT or GPIO_OE directly.

Reset
REQ-016 SHALL, while HRESET=1, asynchronously force GPIO_OUT=0, GPIO_OE=0, A=0, PC=0, wait counter=0, synchronizer flops=0 and state=EXEC.
REQ-017 SHALL, on a reset asserted mid-bus-transaction or mid-WAIT, abort that transaction with no register write, and execute from PC=0 on the first rising edge after release.

Structure
REQ-018 SHALL place opcode constants, register offsets and the state enum in package hazard2_soc_pkg.
REQ-019 SHALL implement the GPIO register block as sub-module hazard2_gpio; the sequencer and ROM SHALL remain in the top.

Verification
REQ-020 SHALL check reset release, with edges counted from the first rising edge with HRESET=0: GPIO_OE=0 until edge 3 and 0x000000FF after edge 3; GPIO_OUT=0 through edge 14.
REQ-021 SHALL check the counter: GPIO_OUT=1 after edge 15, 2 after edge 24, 3 after edge 33, each value stable for exactly 9 cycles.
REQ-022 SHALL check tristate loopback (bench PORT = GPIO_OE!=0 ? GPIO_OUT : Z, fed to GPIO_IN): counter sequence is identical to REQ-021 and no X appears on GPIO_OUT or GPIO_OE after reset.
REQ-023 SHALL check mid-run reset: assert HRESET for 2 cycles when GPIO_OUT=5 -> both outputs go 0 immediately (asynchronous); after release the REQ-020/021 timing repeats from edge 1.
REQ-024 SHALL check parameter override LOOP_WAIT=0 -> GPIO_OUT increments every 5 cycles; LOOP_WAIT=10 -> every 15 cycles.
REQ-025 SHALL check the 10000-cycle run: GPIO_OUT reaches at least 1100 with no sequencer HALT entered.
